// File: rtl/dm_icb_seq.sv
// Single-outstanding ICB master that feeds the debug module's system-side register port.
// Requests are queued in a small FIFO and issued one at a time; each yields read data or a timeout error.
module dm_icb_seq #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [11:0] req_addr,
  input  logic        req_read,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        icb_cmd_valid,
  input  logic        icb_cmd_ready,
  output logic [11:0] icb_cmd_addr,
  output logic        icb_cmd_read,
  output logic [31:0] icb_cmd_wdata,
  input  logic        icb_rsp_valid,
  output logic        icb_rsp_ready,
  input  logic [31:0] icb_rsp_rdata,
  output logic        busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned EW = 45;

  typedef enum logic [1:0] {IDLE, CMD, RSP, DONE} state_t;

  state_t          state, state_nxt;
  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [AW:0]     fcnt;
  logic [CW-1:0]   tcnt;
  logic            stale;
  logic            full, empty, push, pop, cmd_hs, rsp_hs, tmo;

  assign full      = (fcnt == (AW+1)'(DEPTH));
  assign empty     = (fcnt == '0);
  assign req_ready = ~full;
  assign push      = req_valid & ~full;

  assign icb_cmd_valid = (state == CMD);
  assign icb_rsp_ready = (state == RSP) | stale;
  assign rsp_valid     = (state == DONE);
  assign busy          = ~empty | (state != IDLE) | stale;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and per-cycle handshake decode
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    cmd_hs    = 1'b0;
    rsp_hs    = 1'b0;
    tmo       = 1'b0;
    case (state)
      IDLE: if (!empty && !stale) begin
        pop       = 1'b1;
        state_nxt = CMD;
      end
      CMD: if (icb_cmd_ready) begin
        cmd_hs    = 1'b1;
        state_nxt = RSP;
      end
      RSP: begin
        // A response arriving on the deadline cycle still wins over the timeout
        if (icb_rsp_valid) begin
          rsp_hs    = 1'b1;
          state_nxt = DONE;
        end else if ((TIMEOUT != 0) && (tcnt == CW'(TIMEOUT))) begin
          tmo       = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO storage, no reset needed: entries are only read after being written
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {req_addr, req_read, req_wdata};
  end

  // Pointers, occupancy, command registers, timeout counter, response and stale tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr          <= '0;
      rptr          <= '0;
      fcnt          <= '0;
      tcnt          <= '0;
      stale         <= 1'b0;
      icb_cmd_addr  <= '0;
      icb_cmd_read  <= 1'b0;
      icb_cmd_wdata <= '0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) begin
        rptr <= rptr + AW'(1);
        {icb_cmd_addr, icb_cmd_read, icb_cmd_wdata} <= mem[rptr];
      end
      if (push && !pop)      fcnt <= fcnt + (AW+1)'(1);
      else if (pop && !push) fcnt <= fcnt - (AW+1)'(1);

      if (cmd_hs)
        tcnt <= '0;
      else if ((state == RSP) && !rsp_hs && !tmo && (tcnt != '1))
        tcnt <= tcnt + CW'(1);

      if (rsp_hs) begin
        rsp_rdata <= icb_cmd_read ? icb_rsp_rdata : 32'd0;
        rsp_err   <= 1'b0;
      end else if (tmo) begin
        rsp_rdata <= 32'd0;
        rsp_err   <= 1'b1;
      end

      // A timed-out response may still arrive later; swallow exactly one
      if (tmo)
        stale <= 1'b1;
      else if (stale && (state != RSP) && icb_rsp_valid)
        stale <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dm_icb_seq.sv
// Directed bench for dm_icb_seq: table of single transactions plus hand-written multi-cycle sequences.
module tb_dm_icb_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_read;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
  logic [11:0] icb_cmd_addr;
  logic [31:0] icb_cmd_wdata;
  logic        icb_rsp_valid, icb_rsp_ready;
  logic [31:0] icb_rsp_rdata;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  dm_icb_seq #(.DEPTH(4), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_read(req_read), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready), .icb_cmd_addr(icb_cmd_addr),
    .icb_cmd_read(icb_cmd_read), .icb_cmd_wdata(icb_cmd_wdata),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready), .icb_rsp_rdata(icb_rsp_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] addr;
    logic        read;
    logic [31:0] wdata;
    logic [31:0] dm_rdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [4];

  // Inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_req(input logic [11:0] a, input logic r, input logic [31:0] d);
    req_valid = 1'b1; req_addr = a; req_read = r; req_wdata = d;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, ".rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, ".cmd_valid"}, 32'(icb_cmd_valid), 32'd0);
    chk({tag, ".cmd_addr"}, 32'(icb_cmd_addr), 32'd0);
    chk({tag, ".cmd_read"}, 32'(icb_cmd_read), 32'd0);
    chk({tag, ".cmd_wdata"}, icb_cmd_wdata, 32'd0);
    chk({tag, ".icb_rsp_ready"}, 32'(icb_rsp_ready), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_cmd(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (icb_cmd_valid) begin ok = 1'b1; break; end
      tick();
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s.cmd_wait: got no icb_cmd_valid expected one within 20 cycles", tag);
    end
  endtask

  // Serve one ICB command with zero-wait handshakes, then consume the local response
  task automatic serve(input string tag, input logic [11:0] a, input logic r, input logic [31:0] d,
                       input logic [31:0] dm_rdata, input logic [31:0] exp_rdata);
    wait_cmd(tag);
    chk({tag, ".addr"}, 32'(icb_cmd_addr), 32'(a));
    chk({tag, ".read"}, 32'(icb_cmd_read), 32'(r));
    chk({tag, ".wdata"}, icb_cmd_wdata, d);
    icb_cmd_ready = 1'b1;
    tick();
    icb_cmd_ready = 1'b0;
    icb_rsp_valid = 1'b1; icb_rsp_rdata = dm_rdata;
    tick();
    icb_rsp_valid = 1'b0;
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, ".rsp_rdata"}, rsp_rdata, exp_rdata);
    chk({tag, ".rsp_err"}, 32'(rsp_err), 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{addr: 12'h010, read: 1'b1, wdata: 32'h0,         dm_rdata: 32'hA5A5_0001, exp_rdata: 32'hA5A5_0001, exp_err: 1'b0};
    vecs[1] = '{addr: 12'h020, read: 1'b0, wdata: 32'hDEAD_BEEF, dm_rdata: 32'h0000_5555, exp_rdata: 32'h0,         exp_err: 1'b0};
    vecs[2] = '{addr: 12'hFFF, read: 1'b1, wdata: 32'h1111_2222, dm_rdata: 32'hFFFF_FFFF, exp_rdata: 32'hFFFF_FFFF, exp_err: 1'b0};
    vecs[3] = '{addr: 12'h004, read: 1'b0, wdata: 32'h8000_0001, dm_rdata: 32'hCAFE_F00D, exp_rdata: 32'h0,         exp_err: 1'b0};

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_read = 1'b0; req_wdata = '0;
    rsp_ready = 1'b0; icb_cmd_ready = 1'b0; icb_rsp_valid = 1'b0; icb_rsp_rdata = '0;
    tick(); tick();
    chk_reset_vals("reset");
    rst = 1'b0;
    tick();

    // Single transactions with exact cycle positions
    for (int v = 0; v < 4; v++) begin
      string t;
      t = $sformatf("vec%0d", v);
      chk({t, ".req_ready"}, 32'(req_ready), 32'd1);
      push_req(vecs[v].addr, vecs[v].read, vecs[v].wdata);
      chk({t, ".no_pass_through"}, 32'(icb_cmd_valid), 32'd0);
      chk({t, ".busy"}, 32'(busy), 32'd1);
      tick();
      chk({t, ".cmd_valid"}, 32'(icb_cmd_valid), 32'd1);
      chk({t, ".addr"}, 32'(icb_cmd_addr), 32'(vecs[v].addr));
      chk({t, ".read"}, 32'(icb_cmd_read), 32'(vecs[v].read));
      chk({t, ".wdata"}, icb_cmd_wdata, vecs[v].wdata);
      icb_cmd_ready = 1'b1;
      tick();
      icb_cmd_ready = 1'b0;
      chk({t, ".rsp_state_ready"}, 32'(icb_rsp_ready), 32'd1);
      chk({t, ".cmd_dropped"}, 32'(icb_cmd_valid), 32'd0);
      icb_rsp_valid = 1'b1; icb_rsp_rdata = vecs[v].dm_rdata;
      tick();
      icb_rsp_valid = 1'b0;
      chk({t, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
      chk({t, ".rsp_rdata"}, rsp_rdata, vecs[v].exp_rdata);
      chk({t, ".rsp_err"}, 32'(rsp_err), 32'(vecs[v].exp_err));
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk({t, ".rsp_cleared"}, 32'(rsp_valid), 32'd0);
      chk({t, ".busy_low"}, 32'(busy), 32'd0);
    end

    // Fill the FIFO while the first write is held in CMD
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("b2b.req_ready%0d", k), 32'(req_ready), 32'd1);
      if (k >= 2) begin
        chk($sformatf("b2b.hold_addr%0d", k), 32'(icb_cmd_addr), 32'h100);
        chk($sformatf("b2b.hold_wdata%0d", k), icb_cmd_wdata, 32'hC0DE_0000);
      end
      push_req(12'(12'h100 + k), 1'b0, 32'hC0DE_0000 + 32'(k));
    end
    chk("b2b.full", 32'(req_ready), 32'd0);
    chk("b2b.cmd_valid", 32'(icb_cmd_valid), 32'd1);
    tick();
    chk("b2b.stable_wdata", icb_cmd_wdata, 32'hC0DE_0000);
    serve("b2b0", 12'h100, 1'b0, 32'hC0DE_0000, 32'hFFFF_0000, 32'h0);
    chk("b2b.full_while_pop", 32'(req_ready), 32'd0);
    for (int k = 1; k < 5; k++)
      serve($sformatf("b2b%0d", k), 12'(12'h100 + k), 1'b0, 32'hC0DE_0000 + 32'(k), 32'h1234_0000, 32'h0);
    chk("b2b.idle_busy", 32'(busy), 32'd0);

    // Response backpressure with a second command queued behind
    push_req(12'h044, 1'b1, 32'h0);
    push_req(12'h048, 1'b1, 32'h0);
    wait_cmd("bp");
    chk("bp.addr", 32'(icb_cmd_addr), 32'h044);
    icb_cmd_ready = 1'b1;
    tick();
    icb_cmd_ready = 1'b0;
    icb_rsp_valid = 1'b1; icb_rsp_rdata = 32'h0BAD_F00D;
    tick();
    icb_rsp_valid = 1'b0; icb_rsp_rdata = 32'h0;
    for (int i = 0; i < 10; i++) begin
      chk("bp.rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp.rsp_rdata", rsp_rdata, 32'h0BAD_F00D);
      chk("bp.no_cmd", 32'(icb_cmd_valid), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp.gap_cycle", 32'(icb_cmd_valid), 32'd0);
    chk("bp.rsp_dropped", 32'(rsp_valid), 32'd0);
    tick();
    chk("bp.next_cmd", 32'(icb_cmd_valid), 32'd1);
    serve("bp2", 12'h048, 1'b1, 32'h0, 32'h5A5A_5A5A, 32'h5A5A_5A5A);

    // Timeout followed by a late response that must be discarded
    push_req(12'h050, 1'b1, 32'h0);
    push_req(12'h060, 1'b1, 32'h0);
    wait_cmd("tmo");
    chk("tmo.addr", 32'(icb_cmd_addr), 32'h050);
    icb_cmd_ready = 1'b1;
    tick();
    icb_cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("tmo.wait%0d", i), 32'(rsp_valid), 32'd0);
      chk($sformatf("tmo.rsp_ready%0d", i), 32'(icb_rsp_ready), 32'd1);
      tick();
    end
    chk("tmo.rsp_valid", 32'(rsp_valid), 32'd1);
    chk("tmo.rsp_err", 32'(rsp_err), 32'd1);
    chk("tmo.rsp_rdata", rsp_rdata, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("tmo.stale_ready", 32'(icb_rsp_ready), 32'd1);
      chk("tmo.stale_blocks", 32'(icb_cmd_valid), 32'd0);
      chk("tmo.stale_busy", 32'(busy), 32'd1);
      tick();
    end
    icb_rsp_valid = 1'b1; icb_rsp_rdata = 32'h7777_7777;
    tick();
    icb_rsp_valid = 1'b0; icb_rsp_rdata = 32'h0;
    chk("tmo.stale_cleared", 32'(icb_rsp_ready), 32'd0);
    chk("tmo.late_dropped", 32'(rsp_valid), 32'd0);
    chk("tmo.not_yet", 32'(icb_cmd_valid), 32'd0);
    tick();
    chk("tmo.next_cmd", 32'(icb_cmd_valid), 32'd1);
    serve("tmo2", 12'h060, 1'b1, 32'h0, 32'h2222_2222, 32'h2222_2222);

    // Response arriving in the same cycle the counter reaches the limit
    push_req(12'h070, 1'b1, 32'h0);
    wait_cmd("dl");
    icb_cmd_ready = 1'b1;
    tick();
    icb_cmd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("dl.wait%0d", i), 32'(rsp_valid), 32'd0);
      tick();
    end
    icb_rsp_valid = 1'b1; icb_rsp_rdata = 32'h0000_1234;
    tick();
    icb_rsp_valid = 1'b0; icb_rsp_rdata = 32'h0;
    chk("dl.rsp_valid", 32'(rsp_valid), 32'd1);
    chk("dl.rsp_err", 32'(rsp_err), 32'd0);
    chk("dl.rsp_rdata", rsp_rdata, 32'h0000_1234);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("dl.no_stale", 32'(icb_rsp_ready), 32'd0);
    chk("dl.busy", 32'(busy), 32'd0);

    // Reset while waiting for a response with two entries queued
    push_req(12'h080, 1'b1, 32'h0);
    push_req(12'h084, 1'b1, 32'h0);
    push_req(12'h088, 1'b1, 32'h0);
    wait_cmd("rst");
    icb_cmd_ready = 1'b1;
    tick();
    icb_cmd_ready = 1'b0;
    chk("rst.in_rsp", 32'(icb_rsp_ready), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_vals("rst_mid");
    for (int i = 0; i < 6; i++) begin
      chk("rst.no_cmd", 32'(icb_cmd_valid), 32'd0);
      chk("rst.idle", 32'(busy), 32'd0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
